// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : wait-stated word RAM answering MEM-stage load/store
// requests with a combinational stall and a one-cycle ready pulse.
// Revision 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_rd, cap_wr;
    logic        req, complete;

    logic [31:0] acc_addr, acc_wdata;
    logic        acc_rd, acc_wr;
    logic        misaligned, out_of_range, bad, both, mem_we;
    logic [ADDR_W-1:0] idx;

    logic [31:0] mem [2**ADDR_W];

    assign req       = mem_read | mem_write;
    assign mem_stall = req & (state != DONE) & ~rst;
    assign mem_ready = (state == DONE);

    // With zero wait states the access completes on the capture edge itself,
    // so the live inputs are used while idle and the captured copy otherwise.
    assign acc_addr  = (state == IDLE) ? addr      : cap_addr;
    assign acc_wdata = (state == IDLE) ? wdata     : cap_wdata;
    assign acc_rd    = (state == IDLE) ? mem_read  : cap_rd;
    assign acc_wr    = (state == IDLE) ? mem_write : cap_wr;

    assign misaligned   = (acc_addr[1:0] != 2'b00);
    assign out_of_range = (acc_addr[31:ADDR_W+2] != '0);
    assign bad          = misaligned | out_of_range;
    assign both         = acc_rd & acc_wr;
    assign idx          = acc_addr[ADDR_W+1:2];
    assign mem_we       = complete & acc_wr & ~bad & ~rst;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_next = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        complete   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt - 4'd1;
                // Completion lands on the edge where the count reaches zero.
                if (cnt <= 4'd1) begin
                    cnt_next   = 4'd0;
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            rdata     <= 32'd0;
            mem_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_rd    <= mem_read;
                cap_wr    <= mem_write;
            end
            if (complete) begin
                mem_err <= bad | both;
                rdata   <= (acc_rd && !acc_wr && !bad) ? mem[idx] : 32'd0;
            end else if (state == DONE) begin
                mem_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= acc_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_data_mem_responder : scoreboard bench for two responder instances
// (WAIT_CYCLES=2 and WAIT_CYCLES=0) sharing clock and reset.
// Revision 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd2, wr2, rd0, wr0;
    logic [31:0] a2, d2, a0, d0;
    logic [31:0] rdata2, rdata0;
    logic        ready2, stall2, err2, ready0, stall0, err0;

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mem_read(rd2), .mem_write(wr2), .addr(a2), .wdata(d2),
        .rdata(rdata2), .mem_ready(ready2), .mem_stall(stall2), .mem_err(err2)
    );

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_fast (
        .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .addr(a0), .wdata(d0),
        .rdata(rdata0), .mem_ready(ready0), .mem_stall(stall0), .mem_err(err0)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] got_r;
    logic        got_e, ok;
    int          stalls, rdy_i, rdy_cyc;
    exp_t        e;

    task automatic drive(input bit fast, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (fast) begin rd0 = r; wr0 = w; a0 = a; d0 = d; end
        else      begin rd2 = r; wr2 = w; a2 = a; d2 = d; end
    endtask

    task automatic sample(input bit fast, output logic [31:0] r, output logic rdy,
                          output logic st, output logic er);
        if (fast) begin r = rdata0; rdy = ready0; st = stall0; er = err0; end
        else      begin r = rdata2; rdy = ready2; st = stall2; er = err2; end
    endtask

    // Presents one request at a falling edge, holds it until the ready pulse.
    task automatic run_req(input bit fast, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] o_r, output logic o_e, output int n_stall,
                           output int r_i, output int r_cyc, output logic o_ok);
        logic [31:0] sr;
        logic srdy, sst, ser;
        o_ok = 1'b0; o_r = '0; o_e = 1'b0; n_stall = 0; r_i = -1; r_cyc = -1;
        @(negedge clk);
        drive(fast, r, w, a, d);
        for (int i = 0; i < 40; i++) begin
            #1;
            sample(fast, sr, srdy, sst, ser);
            if (srdy) begin
                o_r = sr; o_e = ser; r_i = i; r_cyc = cyc; o_ok = 1'b1;
                break;
            end
            if (sst) n_stall++;
            @(negedge clk);
        end
        drive(fast, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        drive(1'b1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (rdata2 !== 32'd0 || ready2 !== 1'b0 || err2 !== 1'b0 || stall2 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_slow: rdata=%h ready=%b err=%b stall=%b required 0/0/0/0",
                     rdata2, ready2, err2, stall2);
        end
        compared++;
        if (rdata0 !== 32'd0 || ready0 !== 1'b0 || err0 !== 1'b0 || stall0 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_fast: rdata=%h ready=%b err=%b stall=%b required 0/0/0/0",
                     rdata0, ready0, err0, stall0);
        end
    endtask

    task automatic test_write_read;
        sb.push_back('{32'd0, 1'b0});
        run_req(1'b0, 0, 1, 32'h10, 32'hDEADBEEF, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL wr_10: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
        compared++;
        if (stalls !== 3 || rdy_i !== 3) begin
            mismatched++;
            $display("FAIL wr_latency: stall_cycles=%0d ready_at=%0d required 3 and 3", stalls, rdy_i);
        end
        sb.push_back('{32'hDEADBEEF, 1'b0});
        run_req(1'b0, 1, 0, 32'h10, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err || stalls !== 3) begin
            mismatched++;
            $display("FAIL rd_10: ok=%b rdata=%h err=%b stalls=%0d required rdata=%h err=%b stalls=3",
                     ok, got_r, got_e, stalls, e.rdata, e.err);
        end
    endtask

    task automatic test_back_to_back;
        int c1;
        run_req(1'b1, 0, 1, 32'h10, 32'h0BAD0010, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        run_req(1'b1, 0, 1, 32'h14, 32'h0BAD0014, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        sb.push_back('{32'h0BAD0010, 1'b0});
        sb.push_back('{32'h0BAD0014, 1'b0});
        run_req(1'b1, 1, 0, 32'h10, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        c1 = rdy_cyc;
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err || stalls !== 1) begin
            mismatched++;
            $display("FAIL b2b_rd_10: ok=%b rdata=%h err=%b stalls=%0d required rdata=%h err=%b stalls=1",
                     ok, got_r, got_e, stalls, e.rdata, e.err);
        end
        run_req(1'b1, 1, 0, 32'h14, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err || stalls !== 1) begin
            mismatched++;
            $display("FAIL b2b_rd_14: ok=%b rdata=%h err=%b stalls=%0d required rdata=%h err=%b stalls=1",
                     ok, got_r, got_e, stalls, e.rdata, e.err);
        end
        compared++;
        if (rdy_cyc - c1 !== 2) begin
            mismatched++;
            $display("FAIL b2b_gap: ready spacing=%0d cycles required 2", rdy_cyc - c1);
        end
    endtask

    task automatic test_errors;
        run_req(1'b0, 0, 1, 32'h0, 32'hCAFEF00D, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        run_req(1'b0, 1, 0, 32'h0, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        sb.push_back('{32'd0, 1'b1});
        run_req(1'b0, 1, 0, 32'h13, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL misaligned: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
        sb.push_back('{32'd0, 1'b1});
        run_req(1'b0, 0, 1, 32'h1000, 32'hFFFFFFFF, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL out_of_range: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
        sb.push_back('{32'hCAFEF00D, 1'b0});
        run_req(1'b0, 1, 0, 32'h0, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL word0_kept: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
    endtask

    task automatic test_both_ops;
        sb.push_back('{32'd0, 1'b1});
        run_req(1'b0, 1, 1, 32'h20, 32'h12345678, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL rd_wr_both: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
        sb.push_back('{32'h12345678, 1'b0});
        run_req(1'b0, 1, 0, 32'h20, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL rd_20: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
    endtask

    task automatic test_reset_busy;
        run_req(1'b0, 0, 1, 32'h24, 32'hAAAA5555, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        run_req(1'b0, 1, 0, 32'h24, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        @(negedge clk);
        drive(1'b0, 0, 1, 32'h24, 32'h0);
        @(negedge clk);
        #1;
        compared++;
        if (stall2 !== 1'b1 || rdata2 !== 32'hAAAA5555) begin
            mismatched++;
            $display("FAIL busy_before_rst: stall=%b rdata=%h required 1 and aaaa5555", stall2, rdata2);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (stall2 !== 1'b0 || ready2 !== 1'b0 || rdata2 !== 32'd0) begin
            mismatched++;
            $display("FAIL rst_in_busy: stall=%b ready=%b rdata=%h required 0/0/0", stall2, ready2, rdata2);
        end
        drive(1'b0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{32'hAAAA5555, 1'b0});
        run_req(1'b0, 1, 0, 32'h24, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL rd_24_after_rst: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
    endtask

    task automatic test_capture_hold;
        bit seen;
        run_req(1'b0, 0, 1, 32'h34, 32'h34343434, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        @(negedge clk);
        drive(1'b0, 0, 1, 32'h30, 32'h11112222);
        @(negedge clk);
        drive(1'b0, 1, 1, 32'h34, 32'h99999999);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ready2) begin seen = 1'b1; got_e = err2; break; end
            @(negedge clk);
        end
        drive(1'b0, 0, 0, 32'h0, 32'h0);
        compared++;
        if (!seen || got_e !== 1'b0) begin
            mismatched++;
            $display("FAIL capture_done: ready_seen=%b err=%b required 1 and 0", seen, got_e);
        end
        sb.push_back('{32'h11112222, 1'b0});
        sb.push_back('{32'h34343434, 1'b0});
        run_req(1'b0, 1, 0, 32'h30, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL capture_rd_30: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
        run_req(1'b0, 1, 0, 32'h34, 32'h0, got_r, got_e, stalls, rdy_i, rdy_cyc, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || got_r !== e.rdata || got_e !== e.err) begin
            mismatched++;
            $display("FAIL capture_rd_34: ok=%b rdata=%h err=%b required rdata=%h err=%b", ok, got_r, got_e, e.rdata, e.err);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_back_to_back;
        test_errors;
        test_both_ops;
        test_reset_busy;
        test_capture_hold;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
